wired_rf_read_stage: RTL and testbench
======================================

// Module: wired_rf_read_stage
// PURPOSE
//  Register-read pipeline stage directly upstream of the 3-read/1-write 64-entry register RAM.
//  Accepts an issued op with up to three 6-bit source tags and drives the RAM read addresses.
//  Captures the combinational RAM read data, forwards a same-cycle writeback, and presents
//  operands to execute through a 2-entry valid/ready skid buffer. Full throughput: 1 op/cycle.
//  Also owns the RAM write port: the writeback bus passes straight through to it.
// PARAMETERS
//  WIDTH      32  operand / register data width
//  PAYLOAD_W  16  opaque op payload carried alongside operands (uop id, dest tag, ...)
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          issued op present
//  in_ready     out  1          stage can accept (registered)
//  in_src       in   3x6        source register tags 0..2
//  in_src_en    in   3          per-source use flag; unused operand outputs 0
//  in_payload   in   PAYLOAD_W  carried unchanged
//  wb_valid     in   1          writeback strobe
//  wb_addr      in   6          writeback register tag
//  wb_data      in   WIDTH      writeback data
//  rf_addr0/1/2 out  6          RAM read addresses (= in_src[k])
//  rf_dout0/1/2 in   WIDTH      RAM read data, combinational from rf_addrN
//  rf_addrw     out  6          RAM write address (= wb_addr)
//  rf_din       out  WIDTH      RAM write data (= wb_data)
//  rf_wea       out  1          RAM write enable (= wb_valid)
//  out_valid    out  1          operands valid to execute
//  out_ready    in   1          execute accepts
//  out_op       out  3xWIDTH    operands 0..2
//  out_payload  out  PAYLOAD_W  payload of head entry
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, out_op=0, out_payload=0, buffer EMPTY; async assert, sync release.
//  - Accept = in_valid & in_ready. Operands sampled in the accept cycle; out_valid one cycle later.
//  - Operand k = 0 if !in_src_en[k] or in_src[k]==0 (r0 hardwired zero);
//    else bypass value if forwarding hits, else rf_doutk.
//  - Buffer FSM, head feeds outputs, skid holds second op:
//    EMPTY: accept -> ONE.
//    ONE:   accept & fire -> ONE (head replaced); accept & !fire -> TWO (skid loaded);
//           !accept & fire -> EMPTY; else hold.
//    TWO:   in_ready=0; fire -> ONE (skid moves to head); else hold.
//    fire = out_valid & out_ready.
//  - in_ready registered: 1 unless next state is TWO. No combinational path out_ready->in_ready.
//  - Held entries are frozen: a later writeback to a held source tag does NOT update it
//    (issue guarantees sources ready at issue time).
//  - Write port purely combinational pass-through; RAM commits on the following edge.
//  - Simultaneous wb and read of same tag in accept cycle: see CONFIGURATION.
//  - Reset mid-operation drops all buffered ops; no partial output.
// CONFIGURATION
//  WIRED_RF_BYPASS_EN defined: if wb_valid & wb_addr==in_src[k] & wb_addr!=0 in the accept
//    cycle, operand k = wb_data (new value). All three sources compared independently.
//  WIRED_RF_BYPASS_EN undefined: no comparators; operand k = rf_doutk (old value);
//    scheduler must keep a 1-cycle gap between writeback and dependent issue.
// STRUCTURE
//  - Package wired_rf_pkg: rf_tag_t (logic[5:0]), RF_DEPTH=64, RF_ZERO_TAG=0,
//    rf_read_req_t {src[3], src_en, payload}, buffer state enum {EMPTY, ONE, TWO}.
//  - Sub-module wired_rf_operand_sel (one per operand): zero-tag, enable and bypass mux.
//  - Top: FSM, head/skid registers, port wiring.
// TESTING
//  1 Reset: rst_n=0 mid-stream with TWO -> out_valid=0, in_ready=1, out_op all 0 immediately.
//  2 Stream: write r5=0xDEAD_BEEF; 8 ops src0=5 back-to-back, out_ready=1 -> 8 outputs on
//    consecutive cycles, op0=0xDEAD_BEEF, latency 1.
//  3 Backpressure: out_ready=0, issue 3 ops -> 2 held, in_ready=0 after 2nd; release ->
//    outputs in order, no loss/duplication.
//  4 Bypass: r7=0x1, same cycle wb r7=0x2 and issue src1=7 -> op1=0x2 (BYPASS_EN) / 0x1 (off).
//  5 Zero/enable: src0=0 with wb r0=0xFFFF_FFFF, src2 en=0 -> op0=0, op2=0.
//  6 Frozen hold: op src0=9 stalled, then wb r9=0x55 -> held op0 keeps old r9 value.

Source files
------------

// File: rtl/wired_rf_pkg.sv
// Shared types for the wired register-read stage.
// WIRED_RF_BYPASS_EN enables same-cycle writeback forwarding.
package wired_rf_pkg;

    localparam int RF_DEPTH     = 64;
    localparam int RF_TAG_W     = $clog2(RF_DEPTH);
    localparam int RF_PAYLOAD_W = 16;

    typedef logic [RF_TAG_W-1:0] rf_tag_t;

    localparam rf_tag_t RF_ZERO_TAG = '0;

    typedef struct packed {
        rf_tag_t [2:0]           src;
        logic [2:0]              src_en;
        logic [RF_PAYLOAD_W-1:0] payload;
    } rf_read_req_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } rf_buf_state_t;

endpackage

// File: rtl/wired_rf_operand_sel.sv
// Per-operand select: r0/disable force zero, optional writeback bypass.
// Forwarding is built only when WIRED_RF_BYPASS_EN is defined.
module wired_rf_operand_sel
    import wired_rf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  rf_tag_t          src,
    input  logic [WIDTH-1:0] rf_dout,
    input  logic             wb_valid,
    input  rf_tag_t          wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] op
);

    logic hit;

`ifdef WIRED_RF_BYPASS_EN
    assign hit = wb_valid
              && (wb_addr == src)
              && (wb_addr != RF_ZERO_TAG);
`else
    logic unused_wb;
    assign hit       = 1'b0;
    assign unused_wb = ^{wb_valid, wb_addr};
`endif

    always_comb begin
        op = rf_dout;
        if (!en || src == RF_ZERO_TAG) begin
            op = '0;
        end else if (hit) begin
            op = wb_data;
        end
    end

endmodule

// File: rtl/wired_rf_read_stage.sv
// Register-read stage: RAM addressing, operand capture, 2-entry skid.
// WIRED_RF_BYPASS_EN enables same-cycle writeback forwarding.
module wired_rf_read_stage
    import wired_rf_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PAYLOAD_W = RF_PAYLOAD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0][5:0]       in_src,
    input  logic [2:0]            in_src_en,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic                  wb_valid,
    input  logic [5:0]            wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic [5:0]            rf_addr0,
    output logic [5:0]            rf_addr1,
    output logic [5:0]            rf_addr2,
    input  logic [WIDTH-1:0]      rf_dout0,
    input  logic [WIDTH-1:0]      rf_dout1,
    input  logic [WIDTH-1:0]      rf_dout2,
    output logic [5:0]            rf_addrw,
    output logic [WIDTH-1:0]      rf_din,
    output logic                  rf_wea,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0][WIDTH-1:0] out_op,
    output logic [PAYLOAD_W-1:0]  out_payload
);

    rf_read_req_t          req;
    rf_buf_state_t         state, state_nxt;
    logic [2:0][WIDTH-1:0] dout, sel_op;
    logic [2:0][WIDTH-1:0] head_op, skid_op;
    logic [PAYLOAD_W-1:0]  head_pl, skid_pl;
    logic                  accept, fire;
    logic                  load_head, load_skid, pop_skid;

    assign req.src     = in_src;
    assign req.src_en  = in_src_en;
    assign req.payload = RF_PAYLOAD_W'(in_payload);

    assign rf_addr0 = req.src[0];
    assign rf_addr1 = req.src[1];
    assign rf_addr2 = req.src[2];
    assign dout     = {rf_dout2, rf_dout1, rf_dout0};

    assign rf_addrw = wb_addr;
    assign rf_din   = wb_data;
    assign rf_wea   = wb_valid;

    for (genvar k = 0; k < 3; k++) begin : g_sel
        wired_rf_operand_sel #(.WIDTH(WIDTH)) u_sel (
            .en       (req.src_en[k]),
            .src      (req.src[k]),
            .rf_dout  (dout[k]),
            .wb_valid (wb_valid),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .op       (sel_op[k])
        );
    end

    assign out_valid   = (state != EMPTY);
    assign out_op      = head_op;
    assign out_payload = head_pl;
    assign accept      = in_valid && in_ready;
    assign fire        = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (fire) begin
                    state_nxt = ONE;
                    pop_skid  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready comes from next state only, so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            head_op  <= '0;
            head_pl  <= '0;
            skid_op  <= '0;
            skid_pl  <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (load_head) begin
                head_op <= sel_op;
                head_pl <= PAYLOAD_W'(req.payload);
            end else if (pop_skid) begin
                head_op <= skid_op;
                head_pl <= skid_pl;
            end
            if (load_skid) begin
                skid_op <= sel_op;
                skid_pl <= PAYLOAD_W'(req.payload);
            end
        end
    end

endmodule

// File: tb/tb_wired_rf_read_stage.sv
// Bench for wired_rf_read_stage with a RAM model and operand scoreboard.
// Expectations follow WIRED_RF_BYPASS_EN when it is defined.
module tb_wired_rf_read_stage;

    localparam int WIDTH = 32;
    localparam int PW    = 16;

    typedef struct packed {
        logic [2:0][WIDTH-1:0] op;
        logic [PW-1:0]         pl;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0][5:0]       in_src;
    logic [2:0]            in_src_en;
    logic [PW-1:0]         in_payload;
    logic                  wb_valid;
    logic [5:0]            wb_addr;
    logic [WIDTH-1:0]      wb_data;
    logic [5:0]            rf_addr0, rf_addr1, rf_addr2, rf_addrw;
    logic [WIDTH-1:0]      rf_dout0, rf_dout1, rf_dout2, rf_din;
    logic                  rf_wea;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0][WIDTH-1:0] out_op;
    logic [PW-1:0]         out_payload;

    logic [WIDTH-1:0] rf_mem [64];
    ent_t             exp_q [$];
    int               n_tests = 0;
    int               n_fail  = 0;

    always #5 clk = ~clk;

    assign rf_dout0 = rf_mem[rf_addr0];
    assign rf_dout1 = rf_mem[rf_addr1];
    assign rf_dout2 = rf_mem[rf_addr2];

    always @(posedge clk) begin
        if (rf_wea) rf_mem[rf_addrw] <= rf_din;
    end

    wired_rf_read_stage #(.WIDTH(WIDTH), .PAYLOAD_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src      (in_src),
        .in_src_en   (in_src_en),
        .in_payload  (in_payload),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rf_addr0    (rf_addr0),
        .rf_addr1    (rf_addr1),
        .rf_addr2    (rf_addr2),
        .rf_dout0    (rf_dout0),
        .rf_dout1    (rf_dout1),
        .rf_dout2    (rf_dout2),
        .rf_addrw    (rf_addrw),
        .rf_din      (rf_din),
        .rf_wea      (rf_wea),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_payload (out_payload)
    );

    // Reference: the value the register file holds for tag k at issue time
    function automatic logic [WIDTH-1:0] model_op(int k);
        if (!in_src_en[k] || in_src[k] == 6'd0) return '0;
`ifdef WIRED_RF_BYPASS_EN
        if (wb_valid && wb_addr == in_src[k]) return wb_data;
`endif
        return rf_mem[in_src[k]];
    endfunction

    task automatic rand_req();
        for (int k = 0; k < 3; k++) in_src[k] = 6'($urandom);
        in_src_en  = 3'($urandom);
        in_payload = PW'($urandom);
    endtask

    task automatic step(output bit acc, output bit fir,
                        output ent_t got, output ent_t want);
        ent_t m;
        #1;
        acc  = in_valid && in_ready;
        fir  = out_valid && out_ready;
        got  = {out_op, out_payload};
        want = '0;
        if (fir) begin
            if (exp_q.size() == 0) want = 'x;
            else want = exp_q.pop_front();
        end
        if (acc) begin
            for (int k = 0; k < 3; k++) m.op[k] = model_op(k);
            m.pl = in_payload;
            exp_q.push_back(m);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [WIDTH-1:0] d);
        bit acc, fir;
        ent_t got, want;
        in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        step(acc, fir, got, want);
        wb_valid = 1'b0;
        if (fir) begin
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wr_out got=%h want=%h", got, want);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        rand_req();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests += 4;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
        if (out_op !== '0) begin
            n_fail++; $display("FAIL rst_out_op got=%h want=0", out_op);
        end
        if (out_payload !== '0) begin
            n_fail++; $display("FAIL rst_payload got=%h want=0", out_payload);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        bit acc, fir;
        ent_t got, want;
        int nacc = 0, nfire = 0, first_acc = -1, first_fire = -1;
        int last_fire = -1, gaps = 0;
        out_ready = 1'b1;
        write_reg(6'd5, 32'hDEAD_BEEF);
        for (int c = 0; c < 20; c++) begin
            rand_req();
            in_valid     = (nacc < 8);
            in_src[0]    = 6'd5;
            in_src_en[0] = 1'b1;
            step(acc, fir, got, want);
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                nacc++;
            end
            if (fir) begin
                n_tests += 2;
                if (got !== want) begin
                    n_fail++; $display("FAIL stream_out got=%h want=%h", got, want);
                end
                if (got.op[0] !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL stream_op0 got=%h want=deadbeef", got.op[0]);
                end
                if (first_fire < 0) first_fire = c;
                else if (c != last_fire + 1) gaps++;
                last_fire = c;
                nfire++;
            end
        end
        in_valid = 1'b0;
        n_tests += 3;
        if (nfire != 8 || nacc != 8) begin
            n_fail++; $display("FAIL stream_count got=%0d/%0d want=8/8", nacc, nfire);
        end
        if (first_fire != first_acc + 1) begin
            n_fail++; $display("FAIL stream_latency got=%0d want=%0d", first_fire, first_acc + 1);
        end
        if (gaps != 0) begin
            n_fail++; $display("FAIL stream_gaps got=%0d want=0", gaps);
        end
    endtask

    task automatic test_backpressure();
        bit acc, fir;
        ent_t got, want;
        int nacc = 0, nfire = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rand_req();
            in_valid = (nacc < 3);
            wb_valid = 1'($urandom);
            wb_addr  = 6'($urandom);
            wb_data  = $urandom;
            step(acc, fir, got, want);
            if (acc) nacc++;
            if (fir) nfire++;
        end
        n_tests += 3;
        if (nacc != 2 || nfire != 0) begin
            n_fail++; $display("FAIL bp_held got=%0d/%0d want=2/0", nacc, nfire);
        end
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
        end
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_valid got=%b want=1", out_valid);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rand_req();
            in_valid = (nacc < 3);
            wb_valid = 1'($urandom);
            wb_addr  = 6'($urandom);
            wb_data  = $urandom;
            step(acc, fir, got, want);
            if (acc) nacc++;
            if (fir) begin
                nfire++;
                n_tests++;
                if (got !== want) begin
                    n_fail++; $display("FAIL bp_out got=%h want=%h", got, want);
                end
            end
        end
        wb_valid = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (nacc != 3 || nfire != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain got=%0d/%0d/%0d want=3/3/0", nacc, nfire, exp_q.size());
        end
    endtask

    task automatic test_bypass();
        bit acc, fir;
        ent_t got, want;
        logic [WIDTH-1:0] e;
`ifdef WIRED_RF_BYPASS_EN
        e = 32'h2;
`else
        e = 32'h1;
`endif
        out_ready = 1'b1;
        write_reg(6'd7, 32'h1);
        rand_req();
        in_src[1] = 6'd7;
        in_src_en = 3'b111;
        in_valid  = 1'b1;
        wb_valid  = 1'b1;
        wb_addr   = 6'd7;
        wb_data   = 32'h2;
        step(acc, fir, got, want);
        in_valid = 1'b0;
        wb_valid = 1'b0;
        step(acc, fir, got, want);
        n_tests += 2;
        if (!fir || got !== want) begin
            n_fail++; $display("FAIL byp_out fire=%b got=%h want=%h", fir, got, want);
        end
        if (got.op[1] !== e) begin
            n_fail++; $display("FAIL byp_op1 got=%h want=%h", got.op[1], e);
        end
    endtask

    task automatic test_zero_en();
        bit acc, fir;
        ent_t got, want;
        out_ready = 1'b1;
        write_reg(6'd12, 32'h1234_5678);
        rand_req();
        in_src[0] = 6'd0;
        in_src[2] = 6'd12;
        in_src_en = 3'b011;
        in_valid  = 1'b1;
        wb_valid  = 1'b1;
        wb_addr   = 6'd0;
        wb_data   = 32'hFFFF_FFFF;
        step(acc, fir, got, want);
        in_valid = 1'b0;
        wb_valid = 1'b0;
        step(acc, fir, got, want);
        n_tests += 3;
        if (!fir || got !== want) begin
            n_fail++; $display("FAIL zero_out fire=%b got=%h want=%h", fir, got, want);
        end
        if (got.op[0] !== '0) begin
            n_fail++; $display("FAIL zero_op0 got=%h want=0", got.op[0]);
        end
        if (got.op[2] !== '0) begin
            n_fail++; $display("FAIL zero_op2 got=%h want=0", got.op[2]);
        end
    endtask

    task automatic test_frozen();
        bit acc, fir;
        ent_t got, want;
        out_ready = 1'b1;
        write_reg(6'd9, 32'h11);
        out_ready    = 1'b0;
        rand_req();
        in_src[0]    = 6'd9;
        in_src_en[0] = 1'b1;
        in_valid     = 1'b1;
        step(acc, fir, got, want);
        in_valid = 1'b0;
        write_reg(6'd9, 32'h55);
        step(acc, fir, got, want);
        out_ready = 1'b1;
        step(acc, fir, got, want);
        n_tests += 2;
        if (!fir || got !== want) begin
            n_fail++; $display("FAIL frz_out fire=%b got=%h want=%h", fir, got, want);
        end
        if (got.op[0] !== 32'h11) begin
            n_fail++; $display("FAIL frz_op0 got=%h want=11", got.op[0]);
        end
    endtask

    task automatic test_random();
        bit acc, fir;
        ent_t got, want;
        for (int c = 0; c < 400; c++) begin
            rand_req();
            for (int k = 0; k < 3; k++) in_src[k] = 6'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            wb_valid  = 1'($urandom);
            wb_addr   = 6'($urandom_range(0, 7));
            wb_data   = $urandom;
            step(acc, fir, got, want);
            if (fir) begin
                n_tests++;
                if (got !== want) begin
                    n_fail++; $display("FAIL rnd_out c=%0d got=%h want=%h", c, got, want);
                end
            end
        end
        in_valid  = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(acc, fir, got, want);
            if (fir) begin
                n_tests++;
                if (got !== want) begin
                    n_fail++; $display("FAIL rnd_drain got=%h want=%h", got, want);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_empty got=%0d/%b want=0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bit acc, fir;
        ent_t got, want;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_req();
        step(acc, fir, got, want);
        rand_req();
        step(acc, fir, got, want);
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_two got=%b/%b want=0/1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests += 3;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_out_valid got=%b want=0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_in_ready got=%b want=1", in_ready);
        end
        if (out_op !== '0) begin
            n_fail++; $display("FAIL mid_out_op got=%h want=0", out_op);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        step(acc, fir, got, want);
        n_tests++;
        if (fir || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_ghost got=%b want=0", out_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf_mem[i] <= $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_bypass();
        test_zero_en();
        test_frozen();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
